// File: rtl/coin_button_debounce_if.sv
// Coin button bundle: raw button lines in, conditioned press level and events out.
// Pure wiring, no latency of its own.
// No backpressure: every signal is a level or a single-cycle event.
interface coin_button_debounce_if #(
  parameter int N_COINS = 3
);
  logic [N_COINS-1:0] coin_raw_i;
  logic               pressed_o;
  logic [N_COINS-1:0] coin_sel_o;
  logic               press_pulse_o;
  logic               release_pulse_o;
  logic               conflict_o;

  // Button side: drives the raw lines and consumes the conditioned outputs.
  modport master (
    output coin_raw_i,
    input  pressed_o,
    input  coin_sel_o,
    input  press_pulse_o,
    input  release_pulse_o,
    input  conflict_o
  );

  // Debouncer side.
  modport slave (
    input  coin_raw_i,
    output pressed_o,
    output coin_sel_o,
    output press_pulse_o,
    output release_pulse_o,
    output conflict_o
  );
endinterface

// File: rtl/coin_button_debounce.sv
// Synchronise, debounce and arbitrate coin buttons into one clean held level plus events.
// Latency: raw stable -> pressed_o change after DEBOUNCE_CYCLES+3 edges (2 sync + 1 capture + count).
// No backpressure: outputs are registered levels/pulses, the consumer samples them every cycle.
module coin_button_debounce #(
  parameter int N_COINS         = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_ni,
  coin_button_debounce_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_e;

  logic [N_COINS-1:0] sync1_q, sync1_d;
  logic [N_COINS-1:0] sync2_q, sync2_d;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_COINS-1:0] cand_q, cand_d;

  logic               pressed_q, pressed_d;
  logic [N_COINS-1:0] coin_sel_q, coin_sel_d;
  logic               press_pulse_q, press_pulse_d;
  logic               release_pulse_q, release_pulse_d;
  logic               conflict_q, conflict_d;

  logic [N_COINS-1:0] lowest_set;
  logic               cand_hit;
  logic               held_next;

  // Two-stage synchroniser inputs; the FSM only ever looks at sync2_q.
  always_comb begin
    sync1_d = bus.coin_raw_i;
    sync2_d = sync1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // FSM state, debounce counter and locked candidate coin.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Next state: the candidate is fixed on leaving IDLE and is the only bit watched until IDLE again.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    // Isolate the lowest set bit so simultaneous presses resolve to the lowest index.
    lowest_set = sync2_q & (~sync2_q + N_COINS'(1));
    cand_hit   = |(sync2_q & cand_q);
    case (state_q)
      IDLE: begin
        if (|sync2_q) begin
          cand_d  = lowest_set;
          cnt_d   = '0;
          state_d = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (!cand_hit) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!cand_hit) begin
          cnt_d   = '0;
          state_d = DEB_REL;
        end
      end
      DEB_REL: begin
        if (cand_hit) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs derived from the upcoming state so the registered outputs line up with that state.
  always_comb begin
    held_next       = (state_d == HELD) || (state_d == DEB_REL);
    pressed_d       = held_next;
    coin_sel_d      = held_next ? cand_d : '0;
    press_pulse_d   = (state_q == DEB_PRESS) && (state_d == HELD);
    release_pulse_d = (state_q == DEB_REL) && (state_d == IDLE);
    conflict_d      = held_next && (|(sync2_q & ~cand_d));
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      pressed_q       <= 1'b0;
      coin_sel_q      <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      conflict_q      <= 1'b0;
    end else begin
      pressed_q       <= pressed_d;
      coin_sel_q      <= coin_sel_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      conflict_q      <= conflict_d;
    end
  end

  assign bus.pressed_o       = pressed_q;
  assign bus.coin_sel_o      = coin_sel_q;
  assign bus.press_pulse_o   = press_pulse_q;
  assign bus.release_pulse_o = release_pulse_q;
  assign bus.conflict_o      = conflict_q;

endmodule

// File: tb/tb_coin_button_debounce.sv
// Bench for coin_button_debounce: DEBOUNCE_CYCLES=4 main instance plus a DEBOUNCE_CYCLES=1 instance.
// Press/release events are queued with their expected cycle and coin when stimulus is driven.
module tb_coin_button_debounce;

  logic clk = 1'b0;
  logic reset_ni;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    bit         rel;
    int         at;
    logic [2:0] sel;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  coin_button_debounce_if #(.N_COINS(3)) bus_a ();
  coin_button_debounce_if #(.N_COINS(3)) bus_b ();

  coin_button_debounce #(.N_COINS(3), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (bus_a)
  );

  coin_button_debounce #(.N_COINS(3), .DEBOUNCE_CYCLES(1)) dut_b (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (bus_b)
  );

  task automatic expect_event(input bit rel, input int at, input logic [2:0] sel);
    exp_q.push_back('{rel, at, sel});
  endtask

  // Advance n cycles, draining the scoreboard whenever dut_a emits an event.
  task automatic advance(input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus_a.press_pulse_o === 1'b1 || bus_a.release_pulse_o === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected_event: got press=%0b release=%0b at cycle %0d, required no event",
                   bus_a.press_pulse_o, bus_a.release_pulse_o, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus_a.release_pulse_o !== e.rel || cyc != e.at || bus_a.coin_sel_o !== e.sel) begin
            miscompares++;
            $display("FAIL sb_event: got rel=%0b cycle=%0d sel=%b, required rel=%0b cycle=%0d sel=%b",
                     bus_a.release_pulse_o, cyc, bus_a.coin_sel_o, e.rel, e.at, e.sel);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    reset_ni = 1'b0;
    bus_a.coin_raw_i = 3'b000;
    bus_b.coin_raw_i = 3'b000;
    advance(3);
    vectors++;
    if ({bus_a.pressed_o, bus_a.coin_sel_o, bus_a.press_pulse_o, bus_a.release_pulse_o, bus_a.conflict_o} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_outputs_a: got %b, required 0000000",
               {bus_a.pressed_o, bus_a.coin_sel_o, bus_a.press_pulse_o, bus_a.release_pulse_o, bus_a.conflict_o});
    end
    vectors++;
    if ({bus_b.pressed_o, bus_b.coin_sel_o, bus_b.press_pulse_o, bus_b.release_pulse_o, bus_b.conflict_o} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_outputs_b: got %b, required 0000000",
               {bus_b.pressed_o, bus_b.coin_sel_o, bus_b.press_pulse_o, bus_b.release_pulse_o, bus_b.conflict_o});
    end
    reset_ni = 1'b1;
    advance(3);
    vectors++;
    if (bus_a.pressed_o !== 1'b0 || bus_a.press_pulse_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_exit_quiet: got pressed=%b pulse=%b, required 0 0", bus_a.pressed_o, bus_a.press_pulse_o);
    end
  endtask

  task automatic test_clean_press;
    int t;
    bus_a.coin_raw_i = 3'b010;
    t = cyc;
    expect_event(1'b0, t + 7, 3'b010);
    advance(6);
    vectors++;
    if (bus_a.pressed_o !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_press_early: got pressed=%b after 6 edges, required 0", bus_a.pressed_o);
    end
    advance(1);
    vectors++;
    if (bus_a.pressed_o !== 1'b1 || bus_a.coin_sel_o !== 3'b010 || bus_a.press_pulse_o !== 1'b1 || bus_a.conflict_o !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_press_held: got pressed=%b sel=%b pulse=%b conflict=%b, required 1 010 1 0",
               bus_a.pressed_o, bus_a.coin_sel_o, bus_a.press_pulse_o, bus_a.conflict_o);
    end
    advance(1);
    vectors++;
    if (bus_a.press_pulse_o !== 1'b0 || bus_a.pressed_o !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_press_pulse_width: got pulse=%b pressed=%b, required 0 1", bus_a.press_pulse_o, bus_a.pressed_o);
    end
    bus_a.coin_raw_i = 3'b000;
    t = cyc;
    expect_event(1'b1, t + 7, 3'b000);
    advance(6);
    vectors++;
    if (bus_a.pressed_o !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_release_early: got pressed=%b after 6 edges, required 1", bus_a.pressed_o);
    end
    advance(1);
    vectors++;
    if (bus_a.pressed_o !== 1'b0 || bus_a.coin_sel_o !== 3'b000) begin
      miscompares++;
      $display("FAIL clean_release_done: got pressed=%b sel=%b, required 0 000", bus_a.pressed_o, bus_a.coin_sel_o);
    end
    advance(2);
  endtask

  task automatic test_bounce;
    int t;
    logic [4:0] pat;
    pat = 5'b01011;  // applied LSB first: 1,1,0,1,0
    for (int i = 0; i < 5; i++) begin
      bus_a.coin_raw_i = {2'b00, pat[i]};
      advance(1);
    end
    bus_a.coin_raw_i = 3'b001;
    t = cyc;
    expect_event(1'b0, t + 7, 3'b001);
    advance(6);
    vectors++;
    if (bus_a.pressed_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_early: got pressed=%b, required 0", bus_a.pressed_o);
    end
    advance(1);
    vectors++;
    if (bus_a.pressed_o !== 1'b1 || bus_a.coin_sel_o !== 3'b001) begin
      miscompares++;
      $display("FAIL bounce_accept: got pressed=%b sel=%b, required 1 001", bus_a.pressed_o, bus_a.coin_sel_o);
    end
    advance(2);
  endtask

  // Entered with coin 0 held from test_bounce.
  task automatic test_release_glitch;
    int t;
    bus_a.coin_raw_i = 3'b000;
    advance(2);
    bus_a.coin_raw_i = 3'b001;
    for (int i = 0; i < 10; i++) begin
      advance(1);
      vectors++;
      if (bus_a.pressed_o !== 1'b1 || bus_a.release_pulse_o !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_hold: got pressed=%b release=%b at step %0d, required 1 0",
                 bus_a.pressed_o, bus_a.release_pulse_o, i);
      end
    end
    bus_a.coin_raw_i = 3'b000;
    t = cyc;
    expect_event(1'b1, t + 7, 3'b000);
    advance(9);
  endtask

  task automatic test_simultaneous;
    int t;
    bus_a.coin_raw_i = 3'b110;
    t = cyc;
    expect_event(1'b0, t + 7, 3'b010);
    advance(7);
    vectors++;
    if (bus_a.coin_sel_o !== 3'b010 || bus_a.conflict_o !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_arbitrate: got sel=%b conflict=%b, required 010 1", bus_a.coin_sel_o, bus_a.conflict_o);
    end
    advance(3);
    vectors++;
    if (bus_a.conflict_o !== 1'b1 || bus_a.pressed_o !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_conflict_held: got conflict=%b pressed=%b, required 1 1", bus_a.conflict_o, bus_a.pressed_o);
    end
    bus_a.coin_raw_i = 3'b100;
    t = cyc;
    expect_event(1'b1, t + 7, 3'b000);
    expect_event(1'b0, t + 12, 3'b100);
    advance(12);
    vectors++;
    if (bus_a.coin_sel_o !== 3'b100 || bus_a.pressed_o !== 1'b1 || bus_a.conflict_o !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_second_coin: got sel=%b pressed=%b conflict=%b, required 100 1 0",
               bus_a.coin_sel_o, bus_a.pressed_o, bus_a.conflict_o);
    end
    bus_a.coin_raw_i = 3'b000;
    t = cyc;
    expect_event(1'b1, t + 7, 3'b000);
    advance(9);
  endtask

  task automatic test_reset_mid;
    int t;
    // Abort during DEB_PRESS.
    bus_a.coin_raw_i = 3'b001;
    advance(4);
    #2 reset_ni = 1'b0;
    #1;
    vectors++;
    if (bus_a.pressed_o !== 1'b0 || bus_a.press_pulse_o !== 1'b0 || bus_a.coin_sel_o !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_deb: got pressed=%b pulse=%b sel=%b, required 0 0 000",
               bus_a.pressed_o, bus_a.press_pulse_o, bus_a.coin_sel_o);
    end
    advance(1);
    reset_ni = 1'b1;
    t = cyc;
    expect_event(1'b0, t + 7, 3'b001);
    advance(6);
    vectors++;
    if (bus_a.pressed_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_restart1: got pressed=%b after 6 edges, required 0", bus_a.pressed_o);
    end
    advance(1);
    vectors++;
    if (bus_a.pressed_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_accept1: got pressed=%b, required 1", bus_a.pressed_o);
    end
    // Abort while HELD: outputs must drop without waiting for a clock edge.
    advance(2);
    #2 reset_ni = 1'b0;
    #1;
    vectors++;
    if ({bus_a.pressed_o, bus_a.coin_sel_o, bus_a.press_pulse_o, bus_a.release_pulse_o, bus_a.conflict_o} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_mid_held: got %b, required 0000000",
               {bus_a.pressed_o, bus_a.coin_sel_o, bus_a.press_pulse_o, bus_a.release_pulse_o, bus_a.conflict_o});
    end
    advance(1);
    reset_ni = 1'b1;
    t = cyc;
    expect_event(1'b0, t + 7, 3'b001);
    advance(6);
    vectors++;
    if (bus_a.pressed_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_restart2: got pressed=%b after 6 edges, required 0", bus_a.pressed_o);
    end
    advance(1);
    vectors++;
    if (bus_a.pressed_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_accept2: got pressed=%b, required 1", bus_a.pressed_o);
    end
    bus_a.coin_raw_i = 3'b000;
    t = cyc;
    expect_event(1'b1, t + 7, 3'b000);
    advance(9);
  endtask

  task automatic test_debounce_one;
    bus_b.coin_raw_i = 3'b001;
    advance(3);
    vectors++;
    if (bus_b.pressed_o !== 1'b0) begin
      miscompares++;
      $display("FAIL deb1_early: got pressed=%b after 3 edges, required 0", bus_b.pressed_o);
    end
    advance(1);
    vectors++;
    if (bus_b.pressed_o !== 1'b1 || bus_b.press_pulse_o !== 1'b1 || bus_b.coin_sel_o !== 3'b001) begin
      miscompares++;
      $display("FAIL deb1_accept: got pressed=%b pulse=%b sel=%b, required 1 1 001",
               bus_b.pressed_o, bus_b.press_pulse_o, bus_b.coin_sel_o);
    end
    bus_b.coin_raw_i = 3'b000;
    for (int i = 0; i < 4; i++) begin
      advance(1);
      vectors++;
      if (dut_b.cnt_q !== 1'b0 ||
          $isunknown({bus_b.pressed_o, bus_b.coin_sel_o, bus_b.press_pulse_o, bus_b.release_pulse_o, bus_b.conflict_o})) begin
        miscompares++;
        $display("FAIL deb1_cnt_noX: got cnt=%b outputs=%b at step %0d, required cnt 0 and no X", dut_b.cnt_q,
                 {bus_b.pressed_o, bus_b.coin_sel_o, bus_b.press_pulse_o, bus_b.release_pulse_o, bus_b.conflict_o}, i);
      end
    end
    vectors++;
    if (bus_b.pressed_o !== 1'b0 || bus_b.release_pulse_o !== 1'b1) begin
      miscompares++;
      $display("FAIL deb1_release: got pressed=%b release=%b, required 0 1", bus_b.pressed_o, bus_b.release_pulse_o);
    end
  endtask

  task automatic test_drain;
    advance(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid();
    test_debounce_one();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time 100000, required completion");
    $fatal(1);
  end

endmodule
